// File: rtl/memc_collect_if.sv
// Port bundle for memc_collect: capture strobe/data, row read request and read-back row.
// Cin/Cout elements are signed two's-complement values of BITS_C bits, element j at [j].
interface memc_collect_if #(
    parameter int BITS_C = 16,
    parameter int DIM    = 8
);
    logic                          start;
    logic                          en;
    logic [DIM-1:0][BITS_C-1:0]    Cin;
    logic                          rd_en;
    logic [$clog2(DIM)-1:0]        Crow;
    logic [DIM-1:0][BITS_C-1:0]    Cout;
    logic                          Cout_valid;
    logic                          busy;
    logic                          done;

    modport master (
        output start, en, Cin, rd_en, Crow,
        input  Cout, Cout_valid, busy, done
    );

    modport slave (
        input  start, en, Cin, rd_en, Crow,
        output Cout, Cout_valid, busy, done
    );
endinterface

// File: rtl/memc_collect.sv
// De-skews the diagonal C stream from the systolic array into a DIM x DIM matrix, then serves rows.
// Latency: one slice per en cycle; row read is registered, 1 cycle. No backpressure: en stalls capture.
// Build option MEMC_ACCUM_EN: capture adds into storage (mod 2^BITS_C) and start no longer clears it.
module memc_collect #(
    parameter int BITS_C = 16,
    parameter int DIM    = 8
) (
    input  logic            clk,
    input  logic            rst,
    memc_collect_if.slave   cif
);
    localparam int KW   = $clog2(2*DIM - 1);
    localparam int LAST = 2*DIM - 2;

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t                                  state, state_nxt;
    logic [KW-1:0]                           k;
    logic [DIM-1:0][DIM-1:0][BITS_C-1:0]     mem;
    logic                                    clear;
    logic                                    consume;
    logic                                    read_ok;

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        consume   = 1'b0;
        case (state)
            IDLE, DONE: begin
                // start wins over a coincident en; that slice is dropped
                if (cif.start) begin
                    state_nxt = CAPTURE;
                    clear     = 1'b1;
                end
            end
            CAPTURE: begin
                if (cif.en) begin
                    consume = 1'b1;
                    if (k == KW'(LAST))
                        state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign read_ok  = cif.rd_en && (state != CAPTURE);
    assign cif.busy = (state == CAPTURE);
    assign cif.done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            k              <= '0;
            mem            <= '0;
            cif.Cout       <= '0;
            cif.Cout_valid <= 1'b0;
        end else begin
            state <= state_nxt;

            if (clear)
                k <= '0;
            else if (consume)
                k <= k + 1'b1;

`ifndef MEMC_ACCUM_EN
            if (clear)
                mem <= '0;
`endif
            // slice k carries C[r][j] on column j exactly when r + j == k
            for (int r = 0; r < DIM; r++) begin
                for (int j = 0; j < DIM; j++) begin
                    if (consume && (int'(k) == r + j)) begin
`ifdef MEMC_ACCUM_EN
                        mem[r][j] <= mem[r][j] + cif.Cin[j];
`else
                        mem[r][j] <= cif.Cin[j];
`endif
                    end
                end
            end

            // reads sample pre-clear contents on a coincident start edge
            cif.Cout_valid <= read_ok;
            if (read_ok)
                cif.Cout <= mem[cif.Crow];
        end
    end
endmodule

// File: tb/tb_memc_collect.sv
// Directed + random bench for memc_collect against a matrix-level reference model.
module tb_memc_collect;
    localparam int BITS_C = 16;
    localparam int DIM    = 8;
    localparam int NS     = 2*DIM - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    memc_collect_if #(.BITS_C(BITS_C), .DIM(DIM)) bus ();

    memc_collect #(.BITS_C(BITS_C), .DIM(DIM)) dut (
        .clk (clk),
        .rst (rst),
        .cif (bus)
    );

    int checks   = 0;
    int failures = 0;

    // reference model: matrix, read register, and capture progress
    logic [BITS_C-1:0] mC    [DIM][DIM];
    logic [BITS_C-1:0] mCout [DIM];
    bit                mvalid;
    int                mstate;   // 0 idle, 1 capturing, 2 complete
    int                mk;

    task automatic chk(input string tag, input logic [BITS_C-1:0] obs, input logic [BITS_C-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [BITS_C-1:0] pat(input int r, input int j);
        return BITS_C'(16*r + j);
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int r = 0; r < DIM; r++)
                for (int j = 0; j < DIM; j++) mC[r][j] = '0;
            for (int j = 0; j < DIM; j++) mCout[j] = '0;
            mvalid = 0; mstate = 0; mk = 0;
        end else begin
            mvalid = bus.rd_en && (mstate != 1);
            if (mvalid)
                for (int j = 0; j < DIM; j++) mCout[j] = mC[bus.Crow][j];
            if (mstate != 1 && bus.start) begin
`ifndef MEMC_ACCUM_EN
                for (int r = 0; r < DIM; r++)
                    for (int j = 0; j < DIM; j++) mC[r][j] = '0;
`endif
                mstate = 1; mk = 0;
            end else if (mstate == 1 && bus.en) begin
                for (int j = 0; j < DIM; j++) begin
                    int r;
                    r = mk - j;
                    if (r >= 0 && r < DIM) begin
`ifdef MEMC_ACCUM_EN
                        mC[r][j] = mC[r][j] + bus.Cin[j];
`else
                        mC[r][j] = bus.Cin[j];
`endif
                    end
                end
                mk++;
                if (mk == NS) mstate = 2;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("busy",  BITS_C'(bus.busy),       BITS_C'(mstate == 1));
        chk("done",  BITS_C'(bus.done),       BITS_C'(mstate == 2));
        chk("valid", BITS_C'(bus.Cout_valid), BITS_C'(mvalid));
        for (int j = 0; j < DIM; j++) chk("cout_model", bus.Cout[j], mCout[j]);
    endtask

    task automatic idle_in();
        bus.start = 0; bus.en = 0; bus.rd_en = 0; bus.Crow = '0;
        for (int j = 0; j < DIM; j++) bus.Cin[j] = BITS_C'($urandom);
    endtask

    task automatic do_reset();
        idle_in(); rst = 1; step(); rst = 0;
    endtask

    // one skewed slice of the 16*r+j pattern; off-diagonal lanes carry garbage
    task automatic slice(input int k, input bit st, input bit rd);
        for (int j = 0; j < DIM; j++)
            bus.Cin[j] = (k - j >= 0 && k - j < DIM) ? pat(k - j, j) : BITS_C'($urandom);
        bus.en = 1; bus.start = st; bus.rd_en = rd; bus.Crow = 3'd1;
        step();
        if (rd) chk("rd_in_capture_valid", BITS_C'(bus.Cout_valid), '0);
        idle_in();
    endtask

    task automatic capture_const(input logic [BITS_C-1:0] v);
        bus.start = 1; step(); bus.start = 0;
        for (int k = 0; k < NS; k++) begin
            for (int j = 0; j < DIM; j++) bus.Cin[j] = v;
            bus.en = 1; step();
        end
        idle_in();
    endtask

    task automatic read_pattern();
        for (int r = 0; r < DIM; r++) begin
            bus.rd_en = 1; bus.Crow = 3'(r); step();
            chk("row_valid", BITS_C'(bus.Cout_valid), 1);
            for (int j = 0; j < DIM; j++) chk("row_pattern", bus.Cout[j], pat(r, j));
        end
        idle_in();
    endtask

    task automatic read_const(input logic [BITS_C-1:0] v);
        for (int r = 0; r < DIM; r++) begin
            bus.rd_en = 1; bus.Crow = 3'(r); step();
            for (int j = 0; j < DIM; j++) chk("row_const", bus.Cout[j], v);
        end
        idle_in();
    endtask

    initial begin
        rst = 1; idle_in();
        for (int r = 0; r < DIM; r++)
            for (int j = 0; j < DIM; j++) mC[r][j] = '0;
        for (int j = 0; j < DIM; j++) mCout[j] = '0;
        mvalid = 0; mstate = 0; mk = 0;

        // reset, then idle read of row 3
        do_reset();
        chk("rst_busy", BITS_C'(bus.busy), 0);
        chk("rst_done", BITS_C'(bus.done), 0);
        chk("rst_valid", BITS_C'(bus.Cout_valid), 0);
        bus.rd_en = 1; bus.Crow = 3'd3; step(); idle_in();
        chk("idle_read_valid", BITS_C'(bus.Cout_valid), 1);
        for (int j = 0; j < DIM; j++) chk("idle_read_zero", bus.Cout[j], '0);

        // contiguous full capture
        bus.start = 1; step(); idle_in();
        for (int k = 0; k < NS; k++) begin
            chk("busy_before_slice", BITS_C'(bus.busy), 1);
            slice(k, 0, 0);
        end
        chk("done_after_last", BITS_C'(bus.done), 1);
        chk("busy_after_last", BITS_C'(bus.busy), 0);
        read_pattern();

        // stalled capture with garbage on stall cycles
        do_reset();
        bus.start = 1; step(); idle_in();
        for (int k = 0; k < NS; k++) begin
            slice(k, 0, 0);
            if (k == 3 || k == 9) begin
                step(); step();
                chk("stall_busy", BITS_C'(bus.busy), 1);
            end
            if (k < NS - 1) chk("stall_not_done", BITS_C'(bus.done), 0);
        end
        chk("stall_done", BITS_C'(bus.done), 1);
        read_pattern();

        // start and reads during capture are ignored
        do_reset();
        bus.start = 1; step(); idle_in();
        for (int k = 0; k < NS; k++) slice(k, k == 5, k == 2 || k == 5 || k == 8);
        chk("ignored_done", BITS_C'(bus.done), 1);
        read_pattern();
`ifdef MEMC_ACCUM_EN
        do_reset();
`endif
        capture_const('1);
        read_const('1);
        // read coinciding with start sees the pre-clear row
        bus.start = 1; bus.rd_en = 1; bus.Crow = 3'd2; step(); idle_in();
        for (int j = 0; j < DIM; j++) chk("read_at_start", bus.Cout[j], '1);

        // mid-capture reset then clean recapture
        do_reset();
        bus.start = 1; step(); idle_in();
        for (int k = 0; k < 7; k++) slice(k, 0, 0);
        bus.en = 1; rst = 1; step(); rst = 0; idle_in();
        chk("abort_busy", BITS_C'(bus.busy), 0);
        chk("abort_done", BITS_C'(bus.done), 0);
        read_const('0);
        bus.start = 1; step(); idle_in();
        for (int k = 0; k < NS; k++) slice(k, 0, 0);
        read_pattern();

        // accumulate vs overwrite
        do_reset();
        capture_const(16'h7FFF);
        capture_const(16'h0001);
`ifdef MEMC_ACCUM_EN
        read_const(16'h8000);
`else
        read_const(16'h0001);
`endif

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            bus.start = ($urandom_range(0, 19) == 0);
            bus.en    = $urandom_range(0, 1);
            bus.rd_en = $urandom_range(0, 1);
            bus.Crow  = 3'($urandom_range(0, DIM - 1));
            for (int j = 0; j < DIM; j++) bus.Cin[j] = BITS_C'($urandom);
            step();
        end
        rst = 0; idle_in();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/memc_collect.md
Name: memc_collect

Overview:
- Result-side counterpart to the skewed operand memories (memA/memB). It receives the diagonally skewed C-column stream leaving the systolic array and de-skews it into a DIM x DIM result matrix.
- Once the matrix is complete, it serves whole rows on request.
- Sits between the systolic array outputs and the host/testbench readback path.

Parameters:
- BITS_C, 16, width of one signed result element
- DIM, 8, array dimension (matrix is DIM x DIM); must be >= 2

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  begin a new capture
- en  input  1  capture strobe; one skewed diagonal slice presented this cycle
- Cin  input  [DIM] x BITS_C signed  skewed column outputs from array; Cin[j] is column j
- rd_en  input  1  row read request
- Crow  input  $clog2(DIM)  row to read
- Cout  output  [DIM] x BITS_C signed  read row data, registered
- Cout_valid  output  1  Cout holds data for the request made the previous cycle
- busy  output  1  capture in progress
- done  output  1  full matrix captured, sticky until next start or reset

Behaviour:
- Single clock domain. Reset is synchronous, active-high, and is the only reset.
- Reset state: FSM in IDLE; slice counter k=0; all storage zero; Cout all zero; Cout_valid=0, busy=0, done=0.
- FSM states:
  - IDLE: start -> CAPTURE. Storage is cleared in the same edge (except under ACCUM_EN).
  - CAPTURE: busy=1. Each cycle with en=1 consumes one slice and increments k. Cycles with en=0 stall; k holds and nothing is written. When a slice with k==2*DIM-2 is consumed, go to DONE.
  - DONE: done=1, busy=0. start -> CAPTURE, clearing done on that edge.
- Capture mapping for slice k:
  - For each column j, row r = k - j. If 0 <= r < DIM, store Cin[j] into C[r][j]; otherwise Cin[j] is ignored.
  - Exactly 2*DIM-1 slices fill the matrix. Slice 0 carries only C[0][0]; slice 2*DIM-2 carries only C[DIM-1][DIM-1].
- start while in CAPTURE is ignored: no restart, no clear.
- en while in IDLE or DONE is ignored.
- Simultaneous start and en in IDLE/DONE: start takes effect and the en slice is not consumed. Capture begins on the next en.
- Reads:
  - rd_en=1 in IDLE or DONE: on the next edge, Cout = C[Crow] (Cout[j] = C[Crow][j]) and Cout_valid=1. Latency is 1 cycle.
  - Back-to-back reads are supported, one row per cycle.
  - rd_en=0: Cout_valid=0 next cycle; Cout holds its last value.
  - rd_en during CAPTURE is ignored: Cout_valid=0, Cout unchanged.
- Reading in IDLE before any capture returns zeros.
- A read on the same edge as start returns the pre-clear contents.
- Reset asserted mid-capture aborts: everything returns to the reset state and partial data is discarded.
- No arithmetic, except under ACCUM_EN. Widths are preserved exactly; no sign extension or truncation.

Optional Feature:
- Macro: MEMC_ACCUM_EN.
- Defined:
  - start does not clear storage.
  - Each captured element is stored as C[r][j] + Cin[j], wrapping modulo 2^BITS_C (two's complement, no saturation). This supports K-tiled products.
  - Storage is cleared only by reset.
- Undefined: plain overwrite on capture, and start clears storage as described above.

Test Plan:
- Reset then idle read: rst 1 cycle, rd_en with Crow=3 -> next cycle Cout all 0, Cout_valid=1, busy=0, done=0.
- Full capture, DIM=8, contiguous en: drive 15 slices with Cin[j] = 16*(k-j) + j for valid r = k-j -> busy high for 15 en cycles, done=1 after slice 14. Reading rows 0..7 back-to-back gives C[r][j] = 16*r + j, valid on each following cycle.
- Stalled capture: same data with en deasserted for 2 cycles after slices 3 and 9 -> identical matrix. done asserts only after the 15th en cycle. Garbage on Cin during stall cycles must not be stored.
- Ignored events: start asserted at slice 5 of a capture, and rd_en during capture -> capture continues unchanged, Cout_valid stays 0. After done, start then 15 slices of value -1 -> every element reads -1 (0xFFFF).
- Mid-capture reset: rst at slice 7 -> done=0, busy=0, all rows read 0. A new start with 15 slices captures correctly.
- MEMC_ACCUM_EN: two captures of all-0x7FFF, then all-0x0001 -> every element reads 0x8000 (wrap). Without the macro -> every element reads 0x0001.
